// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg -- shared types for the data-memory bridge.
//   bridgeState_t : bridge FSM states (IDLE, WR, RD, RDONE)
//   storeEntry_t  : one store-buffer entry {addr, data}; addr is word aligned
//   wordAlign()   : clears byte-offset bits [1:0]
// Entry addresses are ADDR_MAX bits wide so one struct serves any AW <= 64.
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam int ADDR_MAX = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR    = 2'd1,
    RD    = 2'd2,
    RDONE = 2'd3
  } bridgeState_t;

  typedef struct packed {
    logic [ADDR_MAX-1:0] addr;
    logic [31:0]         data;
  } storeEntry_t;

  function automatic logic [ADDR_MAX-1:0] wordAlign(input logic [ADDR_MAX-1:0] byteAddr);
    return byteAddr & ~ADDR_MAX'(3);
  endfunction

endpackage

// File: rtl/dmem_store_fifo.sv
// -----------------------------------------------------------------------------
// dmem_store_fifo -- DEPTH-entry store buffer (FIFO of storeEntry_t).
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   push, pushEntry : enqueue an entry (caller guarantees not full unless pop)
//   pop             : dequeue the head entry (caller guarantees not empty)
//   headEntry       : oldest entry
//   count           : occupancy, $clog2(DEPTH)+1 bits
//   entries, headPtr: raw storage and head index, only with DMEM_STORE_FWD_EN
// -----------------------------------------------------------------------------
module dmem_store_fifo
  import dmem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  storeEntry_t                pushEntry,
  input  logic                       pop,
  output storeEntry_t                headEntry,
  output logic [$clog2(DEPTH):0]     count
`ifdef DMEM_STORE_FWD_EN
  ,
  output storeEntry_t                entries [DEPTH],
  output logic [$clog2(DEPTH)-1:0]   headPtr
`endif
);

  localparam int PW = $clog2(DEPTH);

  storeEntry_t   slots [DEPTH];
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;

  // NOTE: storage is deliberately not reset; a slot only matters while count
  // covers it, so clearing count and pointers discards the contents.
  always_ff @(posedge clk) begin
    if (push) slots[wrPtr] <= pushEntry;
  end

  // NOTE: all state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      // Pointers are exactly log2(DEPTH) bits, so increment wraps mod DEPTH.
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign headEntry = slots[rdPtr];

`ifdef DMEM_STORE_FWD_EN
  assign entries = slots;
  assign headPtr = rdPtr;
`endif

endmodule

// File: rtl/dmem_bridge.sv
// -----------------------------------------------------------------------------
// dmem_bridge -- connects the core's M stage to a single-request memory port,
// buffering stores in a FIFO and stalling the pipeline on load misses.
// Ports:
//   clk, reset              : clock, asynchronous active-low reset
//   MemWriteM, MemReadM     : store / load request from M stage
//   ALUOutM, WriteDataM     : byte address (bits [1:0] ignored), store data
//   ReadDataM, StallM       : load result, pipeline hold
//   mem_req/we/addr/wdata   : registered memory request, held until mem_ack
//   mem_ack, mem_rdata      : request completion, read data
// Configuration macro DMEM_STORE_FWD_EN: loads hitting a buffered store are
// answered from the buffer (youngest match) and misses bypass buffered stores.
// Without it, loads wait for the buffer to drain. AW must be <= 64.
// -----------------------------------------------------------------------------
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MemWriteM,
  input  logic          MemReadM,
  input  logic [AW-1:0] ALUOutM,
  input  logic [31:0]   WriteDataM,
  output logic [31:0]   ReadDataM,
  output logic          StallM,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  bridgeState_t        state, nextState;
  storeEntry_t         pushEntry, headEntry;
  logic [CW-1:0]       count;
  logic [ADDR_MAX-1:0] reqWord;
  logic [31:0]         rdData;
  logic                push, pop, loadIssue, loadStall;
  logic                unusedAddrHi;

  assign reqWord   = wordAlign(ADDR_MAX'(ALUOutM));
  assign pushEntry = '{addr: reqWord, data: WriteDataM};

  // A full buffer still accepts a store in the cycle its head is acknowledged.
  assign pop  = (state == WR) && mem_ack;
  assign push = MemWriteM && ((count != FULL_COUNT) || pop);

  // Entry address bits above AW are always zero; fold them away explicitly.
  assign unusedAddrHi = ^(headEntry.addr >> AW);

`ifdef DMEM_STORE_FWD_EN
  localparam int PW = $clog2(DEPTH);

  storeEntry_t   entries [DEPTH];
  logic [PW-1:0] headPtr;
  logic          fwdHit;
  logic [31:0]   fwdData;

  dmem_store_fifo #(.DEPTH(DEPTH)) storeFifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pushEntry (pushEntry),
    .pop       (pop),
    .headEntry (headEntry),
    .count     (count),
    .entries   (entries),
    .headPtr   (headPtr)
  );

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    fwdHit  = 1'b0;
    fwdData = '0;
    // Scan oldest to youngest: the last hit is the youngest store to the word.
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < count) && (entries[headPtr + PW'(k)].addr == reqWord)) begin
        fwdHit  = 1'b1;
        fwdData = entries[headPtr + PW'(k)].data;
      end
    end
  end

  assign loadIssue = MemReadM && !fwdHit;
  assign loadStall = !fwdHit && (state != RDONE);
`else
  dmem_store_fifo #(.DEPTH(DEPTH)) storeFifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pushEntry (pushEntry),
    .pop       (pop),
    .headEntry (headEntry),
    .count     (count)
  );

  // Loads are ordered behind every buffered store.
  assign loadIssue = MemReadM && (count == '0);
  assign loadStall = (state != RDONE);
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // Next state: a pending load miss wins over draining the store buffer.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (loadIssue)          nextState = RD;
        else if (count != '0)   nextState = WR;
      end
      WR:      if (mem_ack) nextState = IDLE;
      RD:      if (mem_ack) nextState = RDONE;
      RDONE:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Core-facing outputs; StallM is forced low while reset is asserted.
  always_comb begin
    StallM = 1'b0;
    if (reset) begin
      if (MemWriteM && !push)     StallM = 1'b1;
      if (MemReadM  && loadStall) StallM = 1'b1;
    end
`ifdef DMEM_STORE_FWD_EN
    ReadDataM = (MemReadM && fwdHit) ? fwdData : rdData;
`else
    ReadDataM = rdData;
`endif
  end

  // Memory request registers: loaded on issue from IDLE, held through the ack
  // cycle, and mem_req drops after the ack so IDLE always separates requests.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdData    <= '0;
    end else begin
      if (state == IDLE && nextState == RD) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= AW'(reqWord);
        mem_wdata <= '0;
      end else if (state == IDLE && nextState == WR) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= AW'(headEntry.addr);
        mem_wdata <= headEntry.data;
      end else if ((state == WR || state == RD) && mem_ack) begin
        mem_req <= 1'b0;
      end
      if (state == RD && mem_ack) rdData <= mem_rdata;
    end
  end

endmodule
